// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the core (port 0)
// and the loader/debug port (port 1); one transaction in flight at a time.
module mem_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          last;
   logic          win_id;
   logic          win_we;
   logic          pick;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_wdata;
   logic [DW-1:0] rdata_q;

   // Candidate winner: a lone requester, or the port that did not win last time.
   always_comb begin
      pick = (req0 && req1) ? ~last : req1;
   end

   // Next-state and grant decode; grants only in IDLE and never during reset.
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rst && (req0 || req1)) begin
               gnt0      = ~pick;
               gnt1      = pick;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = win_we ? S_IDLE : S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         last      <= 1'b1;
         win_id    <= 1'b0;
         win_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         state <= state_nxt;
         if (gnt0 || gnt1) begin
            last      <= pick;
            win_id    <= pick;
            win_we    <= pick ? we1 : we0;
            cap_addr  <= pick ? addr1 : addr0;
            cap_wdata <= pick ? wdata1 : wdata0;
         end
         if (state == S_RESP) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // Memory and response outputs decode directly from the state/capture registers.
   assign mem_en    = (state == S_ISSUE);
   assign mem_we    = (state == S_ISSUE) && win_we;
   assign mem_addr  = cap_addr;
   assign mem_wdata = cap_wdata;
   assign busy      = (state != S_IDLE);
   assign rvalid0   = (state == S_RESP) && !win_id;
   assign rvalid1   = (state == S_RESP) && win_id;
   assign rdata     = (state == S_RESP) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-count reference model predicts grants,
// memory strobes and read responses; a separate monitor checks each rvalid.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_en, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] init_val(input int i);
      if (i == 4) return 32'hDEAD_BEEF;
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [5:0] w;
      w = 6'($urandom_range(63));
      return {24'h0, w, 2'b00};
   endfunction

   // Memory macro: 64 words, one-cycle read latency.
   logic [31:0] mem_arr [0:63];
   bit          mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 64; i++) mem_arr[i] = init_val(i);
         mem_loaded = 1'b1;
      end
      if (mem_en === 1'b1) begin
         if (mem_we) mem_arr[mem_addr[7:2]] = mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr[7:2]];
      end
   end

   typedef struct {
      bit          port;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];

   // Reference model: transactions occupy the arbiter for 2 (write) or 3 (read) cycles.
   logic [31:0] ref_mem [0:63];
   bit          last_m = 1'b1;
   bit          m_we   = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   int          free_at = 0;
   int          iss_cyc = -1;

   always @(negedge clk) begin
      bit   iss;
      bit   eg0;
      bit   eg1;
      bit   wp;
      exp_t ne;
      iss = (cyc == iss_cyc);
      chk("mem_en", mem_en, iss);
      chk("mem_we", mem_we, iss && m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("busy", busy, cyc < free_at);
      eg0 = 1'b0;
      eg1 = 1'b0;
      wp  = 1'b0;
      if (!rst && cyc >= free_at && (req0 || req1)) begin
         wp  = (req0 && req1) ? !last_m : req1;
         eg0 = !wp;
         eg1 = wp;
      end
      chk("gnt0", gnt0, eg0);
      chk("gnt1", gnt1, eg1);
      if (eg0 || eg1) begin
         last_m  = wp;
         m_we    = wp ? we1 : we0;
         m_addr  = wp ? addr1 : addr0;
         m_wdata = wp ? wdata1 : wdata0;
         iss_cyc = cyc + 1;
         free_at = cyc + (m_we ? 2 : 3);
         if (m_we) begin
            ref_mem[m_addr[7:2]] = m_wdata;
         end else begin
            ne.port = wp;
            ne.data = ref_mem[m_addr[7:2]];
            ne.due  = cyc + 2;
            sb.push_back(ne);
         end
      end
      if (rst) begin
         last_m  = 1'b1;
         m_we    = 1'b0;
         m_addr  = '0;
         m_wdata = '0;
         iss_cyc = -1;
         free_at = cyc + 1;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due > cyc) sb.delete(i);
         end
      end
   end

   // Monitor: every rvalid must match the oldest expected read response.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
         chk("rvalid_both", rvalid0 && rvalid1, 0);
         if (sb.size() == 0) begin
            chk("rvalid_unexpected", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("rvalid_port", rvalid1, mon_e.port);
            chk("rdata", rdata, mon_e.data);
            chk("rvalid_cycle", cyc, mon_e.due);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         chk("rvalid_missing", 0, 1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input bit p, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] d);
      if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
      else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
   endtask

   // Hold a request until it is granted; returns just after the grant edge.
   task automatic issue(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
      bit granted;
      granted = 1'b0;
      set_port(p, 1'b1, w, a, d);
      for (int k = 0; k < 20 && !granted; k++) begin
         @(negedge clk);
         granted = p ? gnt1 : gnt0;
         step();
      end
      if (p) req1 = 1'b0; else req0 = 1'b0;
      if (!granted) chk("issue_timeout", 0, 1);
   endtask

   task automatic run(input int n, input int pct0, input int pct1, input int wr, input int drop);
      bit g0;
      bit g1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         g0 = gnt0;
         g1 = gnt1;
         step();
         if (req0 && (g0 || $urandom_range(99) < drop)) req0 = 1'b0;
         else if (!req0 && $urandom_range(99) < pct0)
            set_port(1'b0, 1'b1, $urandom_range(99) < wr, rand_addr(), $urandom);
         if (req1 && (g1 || $urandom_range(99) < drop)) req1 = 1'b0;
         else if (!req1 && $urandom_range(99) < pct1)
            set_port(1'b1, 1'b1, $urandom_range(99) < wr, rand_addr(), $urandom);
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
      // Requests during reset must not be granted.
      step();
      req0 = 1'b1;
      req1 = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", {rvalid1, rvalid0}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      step();
      rst  = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;

      issue(1'b0, 1'b0, 32'h10, 32'h0);
      repeat (4) step();
      issue(1'b1, 1'b1, 32'h40, 32'h1234_5678);
      repeat (3) step();
      issue(1'b0, 1'b0, 32'h40, 32'h0);
      repeat (4) step();

      // Both ports reading continuously from a fresh reset: 0,1,0,1...
      pulse_reset();
      run(24, 100, 100, 0, 0);
      repeat (4) step();

      // Reset during ISSUE of a port 0 read abandons it; next contention goes to port 0.
      issue(1'b0, 1'b0, 32'h10, 32'h0);
      pulse_reset();
      repeat (2) step();
      run(8, 100, 100, 0, 0);
      repeat (4) step();

      // req0 only present while port 1 is busy: never served.
      issue(1'b1, 1'b0, 32'h20, 32'h0);
      req0 = 1'b1;
      step();
      step();
      req0 = 1'b0;
      repeat (4) step();

      // Port 0 alone, then contention must go to port 1.
      run(15, 100, 0, 0, 0);
      repeat (4) step();
      run(10, 100, 100, 0, 0);
      repeat (4) step();

      run(3000, 40, 40, 40, 5);
      repeat (6) step();
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
